reg_alu_seq: RTL and testbench



---
 rtl/reg_alu_seq.sv | 131 +++++++++++++
 tb/tb_reg_alu_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_alu_seq.sv
// reg_alu_seq: four-state sequencer that reads two words from an external
// register bank, applies ADD/SUB/AND/XOR and writes the result back.
// One instruction is accepted every four cycles. Nothing is queued while
// an instruction is in flight.

module reg_alu_seq #(
    parameter int M = 32,
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] src1,
    input  logic [N-1:0] src2,
    input  logic [N-1:0] dst,
    output logic [N-1:0] addr1,
    output logic [N-1:0] addr2,
    input  logic [M-1:0] rdata1,
    input  logic [M-1:0] rdata2,
    output logic [N-1:0] addr3,
    output logic [M-1:0] wdata,
    output logic         we,
    output logic         done,
    output logic [M-1:0] result
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    logic [1:0]   state;
    logic [1:0]   nextState;
    logic         handshake;
    logic [1:0]   opQ;
    logic [N-1:0] src1Q;
    logic [N-1:0] src2Q;
    logic [N-1:0] dstQ;
    logic [M-1:0] operandA;
    logic [M-1:0] operandB;
    logic [M-1:0] aluOut;
    logic [M-1:0] resultQ;

    // Only IDLE accepts work; gating with rst_n drops ready as soon as reset asserts.
    assign instr_ready = (state == IDLE) && rst_n;
    assign handshake   = instr_valid && instr_ready;

    // Fixed IDLE -> READ -> EXEC -> WRITE walk, leaving IDLE only on a handshake.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (handshake) nextState = READ;
            READ:    nextState = EXEC;
            EXEC:    nextState = WRITE;
            WRITE:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State register. Async reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Latch the instruction fields on the handshake. The source fields also drive the read addresses, so the addresses hold outside READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opQ   <= '0;
            src1Q <= '0;
            src2Q <= '0;
            dstQ  <= '0;
        end else if (handshake) begin
            opQ   <= op;
            src1Q <= src1;
            src2Q <= src2;
            dstQ  <= dst;
        end
    end

    // Capture both bank words at the end of READ. A later write to dst cannot disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operandA <= '0;
            operandB <= '0;
        end else if (state == READ) begin
            operandA <= rdata1;
            operandB <= rdata2;
        end
    end

    // ALU. Add and subtract simply wrap at the word width.
    always_comb begin
        aluOut = '0;
        case (opQ)
            OP_ADD:  aluOut = operandA + operandB;
            OP_SUB:  aluOut = operandA - operandB;
            OP_AND:  aluOut = operandA & operandB;
            OP_XOR:  aluOut = operandA ^ operandB;
            default: aluOut = '0;
        endcase
    end

    // Register the ALU output at the end of EXEC. It feeds both wdata and result, and it holds until the next instruction reaches EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resultQ <= '0;
        end else if (state == EXEC) begin
            resultQ <= aluOut;
        end
    end

    assign addr1  = src1Q;
    assign addr2  = src2Q;
    assign addr3  = dstQ;
    assign wdata  = resultQ;
    assign result = resultQ;
    assign we     = (state == WRITE);
    assign done   = (state == WRITE);

endmodule

// File: tb/tb_reg_alu_seq.sv
// tb_reg_alu_seq: directed bench for reg_alu_seq with a behavioural
// register bank that has two combinational read ports and one write port.

module tb_reg_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        instrValid;
    logic        instrReady;
    logic [1:0]  opIn;
    logic [9:0]  src1In;
    logic [9:0]  src2In;
    logic [9:0]  dstIn;
    logic [9:0]  addr1;
    logic [9:0]  addr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [9:0]  addr3;
    logic [31:0] wdata;
    logic        we;
    logic        done;
    logic [31:0] result;

    logic [31:0] bank [0:1023];
    logic        loadEn;
    logic [9:0]  loadAddr;
    logic [31:0] loadData;
    int          weCount;
    int          compared;
    int          mismatched;

    reg_alu_seq #(.M(32), .N(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instrValid),
        .instr_ready (instrReady),
        .op          (opIn),
        .src1        (src1In),
        .src2        (src2In),
        .dst         (dstIn),
        .addr1       (addr1),
        .addr2       (addr2),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .addr3       (addr3),
        .wdata       (wdata),
        .we          (we),
        .done        (done),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rdata1 = bank[addr1];
    assign rdata2 = bank[addr2];

    // The bank takes DUT writes, plus preload writes from the bench while the DUT is idle.
    always @(posedge clk) begin
        if (we) begin
            bank[addr3] <= wdata;
        end else if (loadEn) begin
            bank[loadAddr] <= loadData;
        end
    end

    // Count write-enable pulses so that no write can go unseen.
    always @(posedge clk) begin
        if (we) weCount <= weCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Write one bank word through the bench port. Called and returns at a negedge.
    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        loadEn   = 1'b1;
        loadAddr = a;
        loadData = d;
        @(negedge clk);
        loadEn   = 1'b0;
    endtask

    // Offer an instruction and wait for the handshake. Called at a negedge; returns at the negedge after the handshake edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [9:0] s1, input logic [9:0] s2,
                                 input logic [9:0] d, output int waitCycles);
        instrValid = 1'b1;
        opIn       = o;
        src1In     = s1;
        src2In     = s2;
        dstIn      = d;
        waitCycles = 0;
        while (!instrReady && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("ready_seen", 32'(instrReady), 32'd1);
        @(posedge clk);
        @(negedge clk);
        instrValid = 1'b0;
    endtask

    // Run a full instruction and check read addresses, latency, the write and done.
    task automatic doInstr(input logic [1:0] o, input logic [9:0] s1, input logic [9:0] s2,
                           input logic [9:0] d, input logic [31:0] expVal, input string tag,
                           output int waitCycles);
        int lat;
        applyStimulus(o, s1, s2, d, waitCycles);
        checkOutput({tag, "_addr1"}, 32'(addr1), 32'(s1));
        checkOutput({tag, "_addr2"}, 32'(addr2), 32'(s2));
        lat = 1;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, 32'd3);
        checkOutput({tag, "_we"}, 32'(we), 32'd1);
        checkOutput({tag, "_addr3"}, 32'(addr3), 32'(d));
        checkOutput({tag, "_wdata"}, wdata, expVal);
        @(negedge clk);
        checkOutput({tag, "_done_once"}, 32'(done), 32'd0);
        checkOutput({tag, "_bank"}, bank[d], expVal);
        checkOutput({tag, "_result"}, result, expVal);
    endtask

    logic [1:0]  bbOp  [0:2];
    logic [9:0]  bbS1  [0:2];
    logic [9:0]  bbS2  [0:2];
    logic [9:0]  bbDst [0:2];

    initial begin
        int w;
        int lowCnt;
        int weBefore;
        compared   = 0;
        mismatched = 0;
        weCount    = 0;
        rst_n      = 1'b0;
        instrValid = 1'b0;
        opIn       = '0;
        src1In     = '0;
        src2In     = '0;
        dstIn      = '0;
        loadEn     = 1'b0;
        loadAddr   = '0;
        loadData   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 32'(instrReady), 32'd0);
        checkOutput("rst_we", 32'(we), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_addr1", 32'(addr1), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_ready", 32'(instrReady), 32'd1);
        @(negedge clk);

        // ADD: r1=5, r2=7 -> r3=12
        preload(10'd1, 32'd5);
        preload(10'd2, 32'd7);
        doInstr(2'b00, 10'd1, 10'd2, 10'd3, 32'd12, "add", w);

        // SUB wrap: 0 - 1 -> all ones
        preload(10'd1, 32'd0);
        preload(10'd2, 32'd1);
        doInstr(2'b01, 10'd1, 10'd2, 10'd4, 32'hFFFF_FFFF, "sub_wrap", w);

        // In-place add with the same source twice, then an AND that must see the new r5
        preload(10'd5, 32'd9);
        doInstr(2'b00, 10'd5, 10'd5, 10'd5, 32'd18, "inplace", w);
        doInstr(2'b10, 10'd5, 10'd5, 10'd6, 32'd18, "and_new", w);

        // Back-to-back with instr_valid held high: r11=1, r12=2
        preload(10'd11, 32'd1);
        preload(10'd12, 32'd2);
        bbOp[0] = 2'b00; bbS1[0] = 10'd11; bbS2[0] = 10'd12; bbDst[0] = 10'd13;
        bbOp[1] = 2'b00; bbS1[1] = 10'd13; bbS2[1] = 10'd13; bbDst[1] = 10'd14;
        bbOp[2] = 2'b01; bbS1[2] = 10'd14; bbS2[2] = 10'd11; bbDst[2] = 10'd15;
        weBefore = weCount;
        for (int k = 0; k < 3; k++) begin
            instrValid = 1'b1;
            opIn       = bbOp[k];
            src1In     = bbS1[k];
            src2In     = bbS2[k];
            dstIn      = bbDst[k];
            lowCnt     = 0;
            while (!instrReady && lowCnt < 20) begin
                @(negedge clk);
                lowCnt++;
            end
            if (k > 0) checkOutput("b2b_gap", lowCnt + 1, 32'd4);
            @(posedge clk);
            @(negedge clk);
        end
        instrValid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("b2b_we_pulses", weCount - weBefore, 32'd3);
        checkOutput("b2b_r13", bank[13], 32'd3);
        checkOutput("b2b_r14", bank[14], 32'd6);
        checkOutput("b2b_r15", bank[15], 32'd5);

        // Reset during EXEC of an XOR into r7
        preload(10'd7, 32'h1234_5678);
        preload(10'd8, 32'hF0F0_F0F0);
        preload(10'd9, 32'hFFFF_0000);
        weBefore = weCount;
        applyStimulus(2'b11, 10'd8, 10'd9, 10'd7, w);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_we", 32'(we), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_ready", 32'(instrReady), 32'd0);
        checkOutput("abort_addr1", 32'(addr1), 32'd0);
        checkOutput("abort_addr2", 32'(addr2), 32'd0);
        checkOutput("abort_addr3", 32'(addr3), 32'd0);
        checkOutput("abort_wdata", wdata, 32'd0);
        checkOutput("abort_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abort_no_write", weCount - weBefore, 32'd0);
        checkOutput("abort_r7", bank[7], 32'h1234_5678);

        // XOR right after reset, accepted without waiting
        doInstr(2'b11, 10'd8, 10'd9, 10'd10, 32'h0F0F_F0F0, "xor", w);
        checkOutput("xor_no_wait", w, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
